// File: rtl/sha256_target_check.sv
// Bitcoin-style share check: collects the eight second-pass digest words, byte-reverses
// the top 64 bits and compares them against a latched target, holding the first hit.
module sha256_target_check (
    input  logic        clk,
    input  logic        rst,
    input  logic        digest_start,
    input  logic        digest_valid,
    input  logic [31:0] digest_word,
    input  logic [31:0] nonce_in,
    input  logic [63:0] target64,
    input  logic        found_ack,
    output logic        busy,
    output logic        found,
    output logic [31:0] found_nonce,
    output logic [63:0] found_top,
    output logic        lost_hit,
    output logic [31:0] hash_count,
    output logic        seq_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, CMP} state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [31:0] w6;
    logic [31:0] w7;
    logic [31:0] nonce_q;
    logic [63:0] target_q;
    logic [63:0] v64;
    logic        hit;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // The digest is big-endian per word; the value miners compare is the byte-reversed tail.
    assign v64 = {bswap(w7), bswap(w6)};
    assign hit = (v64 <= target_q);

    // NOTE: the datapath registers are reset too, so a digest abandoned by reset
    // leaves no stale words, nonce or target behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            w6          <= '0;
            w7          <= '0;
            nonce_q     <= '0;
            target_q    <= '0;
            busy        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_top   <= '0;
            lost_hit    <= 1'b0;
            hash_count  <= '0;
            seq_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later assignment in this
            // block (a hit in CMP) overrides the acknowledge clear below.
            if (found_ack) begin
                found    <= 1'b0;
                lost_hit <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (digest_valid) seq_err <= 1'b1;
                    if (digest_start) begin
                        state    <= COLLECT;
                        busy     <= 1'b1;
                        idx      <= '0;
                        nonce_q  <= nonce_in;
                        target_q <= target64;
                    end
                end
                COLLECT: begin
                    if (digest_start) begin
                        idx      <= '0;
                        nonce_q  <= nonce_in;
                        target_q <= target64;
                        seq_err  <= 1'b1;
                    end else if (digest_valid) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd6) w6 <= digest_word;
                        if (idx == 3'd7) begin
                            w7    <= digest_word;
                            state <= CMP;
                        end
                    end
                end
                CMP: begin
                    if (digest_start) seq_err <= 1'b1;
                    hash_count <= hash_count + 32'd1;
                    state      <= IDLE;
                    busy       <= 1'b0;
                    if (hit) begin
                        if (!found || found_ack) begin
                            found       <= 1'b1;
                            found_nonce <= nonce_q;
                            found_top   <= v64;
                            lost_hit    <= 1'b0;
                        end else begin
                            lost_hit <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
